exec_unit_operand_cache: RTL and testbench
==========================================

Name: exec_unit_operand_cache

Overview:
Parametrised successor to the fixed single-write xcache/ycache storage used by each ALPU. It holds NUM_ENTRIES operand slots, each with a full/free flag (inverse of has_been_read), and accepts writes from NUM_WR_PORTS channels (local ALPU plus interconnect). It serves NUM_RD_PORTS independent operand reads with consume-on-read semantics. It sits between the interconnect/ALPU tx side and the ALPU op0/op1 rx side, and generates the per-channel ready backpressure.

Parameters:
NUM_ENTRIES, `NUM_REG (16), number of operand slots; power of 2, >=2
DATA_WIDTH, `ALU_REG_WIDTH, operand width
NUM_WR_PORTS, 2, write channels; port 0 has highest priority
NUM_RD_PORTS, 2, read channels (op0, op1)
IDX_W, $clog2(NUM_ENTRIES), derived; not overridable
OCC_W, $clog2(NUM_ENTRIES+1), derived

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_wr_valid  in  NUM_WR_PORTS  per-port write request
i_wr_idx  in  NUM_WR_PORTS*IDX_W  slot index per port (packed, port 0 in LSBs)
i_wr_data  in  NUM_WR_PORTS*DATA_WIDTH  write data per port
o_wr_ready  out  NUM_WR_PORTS  write accepted this cycle when valid&ready
i_rd_idx  in  NUM_RD_PORTS*IDX_W  slot index per read port
i_rd_consume  in  NUM_RD_PORTS  mark slot read (free) at the clock edge if o_rd_valid
o_rd_data  out  NUM_RD_PORTS*DATA_WIDTH  slot data, combinational from storage
o_rd_valid  out  NUM_RD_PORTS  slot is full
i_flush  in  1  synchronous clear of all full flags
o_occupancy  out  OCC_W  number of full slots
o_full  out  1  occupancy == NUM_ENTRIES
o_empty  out  1  occupancy == 0

Behaviour:
- Reset (async, i_nrst=0): all full flags 0; o_occupancy=0; o_empty=1; o_full=0; o_rd_valid=0; o_wr_ready is combinational, so it is high for any valid port with no higher-priority collision. Data storage is not reset. Reset asserted mid-operation clears flags immediately; the writes in flight are lost.
- o_wr_ready[p] = ~full[i_wr_idx[p]] & ~(any q<p with i_wr_valid[q] and i_wr_idx[q]==i_wr_idx[p]). It depends only on registered flags and current requests. There is no combinational path from i_rd_consume.
- Write accept (valid&ready): data and full flag are written at the next edge. Read sees the new data the cycle after accept; write-to-read latency is 1.
- Read: o_rd_valid[r]=full[i_rd_idx[r]]; o_rd_data[r]=mem[i_rd_idx[r]]. Latency is 0, combinational from registers.
- Consume: if i_rd_consume[r]&o_rd_valid[r], the slot's full flag is cleared at the edge. Consume while not valid is ignored.
- Two read ports on the same index may both read. Consuming from both frees the slot once and decrements occupancy once.
- Write to a slot being consumed in the same cycle: refused (ready=0 because the flag is still full). The writer retries and succeeds the next cycle.
- Accepted writes always target distinct free slots, so no write/consume on the same slot can both take effect in one cycle.
- o_occupancy next = occupancy + (#accepted writes) - (#distinct slots consumed). Never wraps; an assertion checks 0..NUM_ENTRIES.
- o_full/o_empty are derived from the registered o_occupancy.
- i_flush=1: all flags and occupancy are cleared next edge. Flush overrides same-cycle writes and consumes; o_wr_ready is forced 0 during flush.
- No state machine beyond per-slot flags. The slot state is FREE -> FULL on accepted write, and FULL -> FREE on consume, flush or reset.

Decomposition:
- Package exec_unit_dtypes gains type_ocache_slot {data[DATA_WIDTH-1:0], full}, replacing the duplicate xcache/ycache structs. It also gains localparam OCACHE_OCC_W.
- Sub-module exec_unit_ocache_wr_arb: combinational per-port index-collision priority and flag check, producing o_wr_ready and accepted one-hot write enables per slot.
- Top holds storage, flags, read muxes, consume decode and the occupancy counter.

Test Plan:
1. Reset, then port0 writes idx3=0x00AB -> ready=1; next cycle rd0 idx3 valid=1, data=0x00AB, occupancy=1.
2. Ports 0 and 1 both write idx5 (0x1111, 0x2222) -> ready0=1, ready1=0; slot5=0x1111; port1 holds, is refused while full, and is accepted the cycle after slot5 is consumed.
3. Slot7 full; rd0 consumes idx7 while port0 writes idx7=0x0042 -> ready0=0; next cycle slot free, write accepted; following cycle valid=1, data=0x0042.
4. rd0 and rd1 both idx2, both consume -> both see the data; occupancy drops by 1 only.
5. Fill all 16 slots -> o_full=1, all wr_ready=0; assert i_flush with a write pending -> next cycle occupancy=0, o_empty=1, write not stored.
6. Drop i_nrst mid-cycle with 4 slots full -> o_occupancy=0 and all rd_valid=0 immediately (asynchronously); after release, a write to idx0 is accepted normally.

Source files
------------

// File: rtl/exec_unit_operand_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_unit_dtypes : shared ALPU operand-cache types and sizes          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package exec_unit_dtypes;

  localparam int OCACHE_NUM_ENTRIES = 16;
  localparam int OCACHE_DATA_WIDTH  = 16;
  localparam int OCACHE_IDX_W       = $clog2(OCACHE_NUM_ENTRIES);
  localparam int OCACHE_OCC_W       = $clog2(OCACHE_NUM_ENTRIES + 1);

  // One operand slot as seen by the ALPU rx side; full is the inverse of has_been_read.
  typedef struct packed {
    logic [OCACHE_DATA_WIDTH-1:0] data;
    logic                         full;
  } type_ocache_slot;

  // Width of a write-port selector; a single port still needs one bit.
  function automatic int ocache_port_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_unit_operand_cache_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_unit_operand_cache_if : write/read/status bundle of the cache    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface exec_unit_operand_cache_if
  import exec_unit_dtypes::*;
#(
  parameter int NUM_ENTRIES  = OCACHE_NUM_ENTRIES,
  parameter int DATA_WIDTH   = OCACHE_DATA_WIDTH,
  parameter int NUM_WR_PORTS = 2,
  parameter int NUM_RD_PORTS = 2
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  logic [NUM_WR_PORTS-1:0]            i_wr_valid;
  logic [NUM_WR_PORTS*IDX_W-1:0]      i_wr_idx;
  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] i_wr_data;
  logic [NUM_WR_PORTS-1:0]            o_wr_ready;
  logic [NUM_RD_PORTS*IDX_W-1:0]      i_rd_idx;
  logic [NUM_RD_PORTS-1:0]            i_rd_consume;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_rd_data;
  logic [NUM_RD_PORTS-1:0]            o_rd_valid;
  logic                               i_flush;
  logic [OCC_W-1:0]                   o_occupancy;
  logic                               o_full;
  logic                               o_empty;

  modport master (
    output i_wr_valid, i_wr_idx, i_wr_data, i_rd_idx, i_rd_consume, i_flush,
    input  o_wr_ready, o_rd_data, o_rd_valid, o_occupancy, o_full, o_empty
  );

  modport slave (
    input  i_wr_valid, i_wr_idx, i_wr_data, i_rd_idx, i_rd_consume, i_flush,
    output o_wr_ready, o_rd_data, o_rd_valid, o_occupancy, o_full, o_empty
  );

endinterface
`default_nettype wire

// File: rtl/exec_unit_ocache_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_unit_ocache_wr_arb : per-port index-collision priority + flag    |
// | check, giving write ready and one-hot slot write enables. Rev 1.0    |
// +----------------------------------------------------------------------+
module exec_unit_ocache_wr_arb
  import exec_unit_dtypes::*;
#(
  parameter int NUM_ENTRIES  = OCACHE_NUM_ENTRIES,
  parameter int NUM_WR_PORTS = 2,
  parameter int IDX_W        = $clog2(NUM_ENTRIES),
  parameter int PORT_W       = ocache_port_w(NUM_WR_PORTS)
) (
  input  logic [NUM_WR_PORTS-1:0]             i_wr_valid,
  input  logic [NUM_WR_PORTS*IDX_W-1:0]       i_wr_idx,
  input  logic [NUM_ENTRIES-1:0]              i_full,
  input  logic                                i_flush,
  output logic [NUM_WR_PORTS-1:0]             o_wr_ready,
  output logic [NUM_ENTRIES-1:0]              o_slot_we,
  output logic [NUM_ENTRIES-1:0][PORT_W-1:0]  o_slot_sel
);

  logic [IDX_W-1:0] w_idx_p;
  logic [IDX_W-1:0] w_idx_q;
  logic             w_collide;

  // Lower port numbers win a shared index; a refused port keeps its request up.
  always_comb begin
    o_wr_ready = '0;
    o_slot_we  = '0;
    o_slot_sel = '0;
    w_idx_p    = '0;
    w_idx_q    = '0;
    w_collide  = 1'b0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      w_idx_p   = i_wr_idx[p*IDX_W +: IDX_W];
      w_collide = 1'b0;
      for (int q = 0; q < p; q++) begin
        w_idx_q = i_wr_idx[q*IDX_W +: IDX_W];
        if (i_wr_valid[q] && (w_idx_q == w_idx_p)) begin
          w_collide = 1'b1;
        end
      end
      o_wr_ready[p] = ~i_flush & ~i_full[w_idx_p] & ~w_collide;
      if (i_wr_valid[p] && o_wr_ready[p]) begin
        o_slot_we[w_idx_p]  = 1'b1;
        o_slot_sel[w_idx_p] = PORT_W'(p);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_unit_operand_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_unit_operand_cache : multi-write, consume-on-read operand slots  |
// | between interconnect/ALPU tx and the ALPU op0/op1 rx. Rev 1.0        |
// +----------------------------------------------------------------------+
module exec_unit_operand_cache
  import exec_unit_dtypes::*;
#(
  parameter int NUM_ENTRIES  = OCACHE_NUM_ENTRIES,
  parameter int DATA_WIDTH   = OCACHE_DATA_WIDTH,
  parameter int NUM_WR_PORTS = 2,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  exec_unit_operand_cache_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int OCC_W  = $clog2(NUM_ENTRIES + 1);
  localparam int PORT_W = ocache_port_w(NUM_WR_PORTS);
  localparam logic [OCC_W-1:0] c_max_occ = OCC_W'(NUM_ENTRIES);

  logic [DATA_WIDTH-1:0]             r_mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]            r_full;
  logic [OCC_W-1:0]                  r_occupancy;

  logic [NUM_WR_PORTS-1:0]           w_wr_ready;
  logic [NUM_ENTRIES-1:0]            w_slot_we;
  logic [NUM_ENTRIES-1:0][PORT_W-1:0] w_slot_sel;
  logic [NUM_ENTRIES-1:0]            w_slot_clr;
  logic [OCC_W-1:0]                  w_wr_cnt;
  logic [OCC_W-1:0]                  w_clr_cnt;
  logic [IDX_W-1:0]                  w_rd_idx;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_RD_PORTS-1:0]           w_rd_valid;

  exec_unit_ocache_wr_arb #(
    .NUM_ENTRIES  (NUM_ENTRIES),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .IDX_W        (IDX_W),
    .PORT_W       (PORT_W)
  ) u_wr_arb (
    .i_wr_valid (bus.i_wr_valid),
    .i_wr_idx   (bus.i_wr_idx),
    .i_full     (r_full),
    .i_flush    (bus.i_flush),
    .o_wr_ready (w_wr_ready),
    .o_slot_we  (w_slot_we),
    .o_slot_sel (w_slot_sel)
  );

  // Read muxes and consume decode; two ports on one slot clear it only once.
  always_comb begin
    w_rd_data  = '0;
    w_rd_valid = '0;
    w_slot_clr = '0;
    w_rd_idx   = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      w_rd_idx                             = bus.i_rd_idx[r*IDX_W +: IDX_W];
      w_rd_valid[r]                        = r_full[w_rd_idx];
      w_rd_data[r*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_rd_idx];
      if (bus.i_rd_consume[r] && r_full[w_rd_idx]) begin
        w_slot_clr[w_rd_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_wr_cnt  = '0;
    w_clr_cnt = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_wr_cnt  = w_wr_cnt  + OCC_W'(w_slot_we[e]);
      w_clr_cnt = w_clr_cnt + OCC_W'(w_slot_clr[e]);
    end
  end

  // Accepted writes only hit free slots and consumes only full ones, so set/clear never overlap.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_full      <= '0;
      r_occupancy <= '0;
    end else if (bus.i_flush) begin
      r_full      <= '0;
      r_occupancy <= '0;
    end else begin
      r_full      <= (r_full & ~w_slot_clr) | w_slot_we;
      r_occupancy <= r_occupancy + w_wr_cnt - w_clr_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (w_slot_we[e]) begin
        r_mem[e] <= bus.i_wr_data[int'(w_slot_sel[e])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.o_wr_ready  = w_wr_ready;
  assign bus.o_rd_data   = w_rd_data;
  assign bus.o_rd_valid  = w_rd_valid;
  assign bus.o_occupancy = r_occupancy;
  assign bus.o_full      = (r_occupancy == c_max_occ);
  assign bus.o_empty     = (r_occupancy == '0);

  a_occ_range : assert property (@(posedge i_clk) disable iff (!i_nrst)
                                 r_occupancy <= c_max_occ);

endmodule
`default_nettype wire

// File: tb/tb_exec_unit_operand_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exec_unit_operand_cache : directed self-checking bench             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_exec_unit_operand_cache;

  localparam int NE = 16;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk;
  logic nrst;
  int   n_tests;
  int   n_fail;
  logic [NE-1:0] model_full;

  exec_unit_operand_cache_if #(
    .NUM_ENTRIES(NE), .DATA_WIDTH(DW), .NUM_WR_PORTS(2), .NUM_RD_PORTS(2)
  ) bus ();

  exec_unit_operand_cache #(
    .NUM_ENTRIES(NE), .DATA_WIDTH(DW), .NUM_WR_PORTS(2), .NUM_RD_PORTS(2)
  ) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int p, input logic v, input logic [IW-1:0] idx,
                          input logic [DW-1:0] data);
    bus.i_wr_valid[p]        = v;
    bus.i_wr_idx[p*IW +: IW] = idx;
    bus.i_wr_data[p*DW +: DW] = data;
  endtask

  task automatic drive_rd(input int r, input logic [IW-1:0] idx, input logic consume);
    bus.i_rd_idx[r*IW +: IW] = idx;
    bus.i_rd_consume[r]      = consume;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_full = '0;
    nrst = 1'b0;
    bus.i_wr_valid   = '0;
    bus.i_wr_idx     = '0;
    bus.i_wr_data    = '0;
    bus.i_rd_idx     = '0;
    bus.i_rd_consume = '0;
    bus.i_flush      = 1'b0;
    #1;
    check_value("rst_occ",      32'(bus.o_occupancy), 32'd0);
    check_value("rst_empty",    32'(bus.o_empty),     32'd1);
    check_value("rst_full",     32'(bus.o_full),      32'd0);
    check_value("rst_rd_valid", 32'(bus.o_rd_valid),  32'd0);
    check_value("rst_wr_ready", 32'(bus.o_wr_ready),  32'h3);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;

    // 1: simple write then read
    drive_wr(0, 1'b1, 4'd3, 16'h00AB);
    #1;
    check_value("t1_ready0", 32'(bus.o_wr_ready[0]), 32'd1);
    tick();
    drive_wr(0, 1'b0, 4'd3, 16'h0000);
    drive_rd(0, 4'd3, 1'b0);
    #1;
    check_value("t1_valid", 32'(bus.o_rd_valid[0]),  32'd1);
    check_value("t1_data",  32'(bus.o_rd_data[15:0]), 32'h00AB);
    check_value("t1_occ",   32'(bus.o_occupancy),     32'd1);
    check_value("t1_empty", 32'(bus.o_empty),         32'd0);

    // 2: same-index collision, port 1 retries until slot consumed
    drive_wr(0, 1'b1, 4'd5, 16'h1111);
    drive_wr(1, 1'b1, 4'd5, 16'h2222);
    #1;
    check_value("t2_ready_pair", 32'(bus.o_wr_ready), 32'h1);
    tick();
    drive_wr(0, 1'b0, 4'd0, 16'h0000);
    drive_rd(0, 4'd5, 1'b0);
    #1;
    check_value("t2_ready1_full", 32'(bus.o_wr_ready[1]), 32'd0);
    check_value("t2_data_p0",     32'(bus.o_rd_data[15:0]), 32'h1111);
    check_value("t2_occ2",        32'(bus.o_occupancy),     32'd2);
    drive_rd(0, 4'd5, 1'b1);
    #1;
    check_value("t2_ready1_consuming", 32'(bus.o_wr_ready[1]), 32'd0);
    tick();
    drive_rd(0, 4'd5, 1'b0);
    #1;
    check_value("t2_ready1_freed", 32'(bus.o_wr_ready[1]), 32'd1);
    check_value("t2_valid_freed",  32'(bus.o_rd_valid[0]), 32'd0);
    tick();
    drive_wr(1, 1'b0, 4'd0, 16'h0000);
    #1;
    check_value("t2_valid_p1", 32'(bus.o_rd_valid[0]),   32'd1);
    check_value("t2_data_p1",  32'(bus.o_rd_data[15:0]), 32'h2222);
    check_value("t2_occ",      32'(bus.o_occupancy),     32'd2);

    // 3: write to a slot being consumed is refused, then retried
    drive_wr(0, 1'b1, 4'd7, 16'h0077);
    tick();
    drive_wr(0, 1'b1, 4'd7, 16'h0042);
    drive_rd(0, 4'd7, 1'b1);
    #1;
    check_value("t3_ready_busy", 32'(bus.o_wr_ready[0]),   32'd0);
    check_value("t3_old_data",   32'(bus.o_rd_data[15:0]), 32'h0077);
    tick();
    drive_rd(0, 4'd7, 1'b0);
    #1;
    check_value("t3_ready_free", 32'(bus.o_wr_ready[0]), 32'd1);
    tick();
    drive_wr(0, 1'b0, 4'd0, 16'h0000);
    #1;
    check_value("t3_valid", 32'(bus.o_rd_valid[0]),   32'd1);
    check_value("t3_data",  32'(bus.o_rd_data[15:0]), 32'h0042);
    check_value("t3_occ",   32'(bus.o_occupancy),     32'd3);

    // 4: both read ports consume the same slot
    drive_wr(1, 1'b1, 4'd2, 16'h0BEE);
    tick();
    drive_wr(1, 1'b0, 4'd0, 16'h0000);
    drive_rd(0, 4'd2, 1'b1);
    drive_rd(1, 4'd2, 1'b1);
    #1;
    check_value("t4_occ_before", 32'(bus.o_occupancy),      32'd4);
    check_value("t4_valid_both", 32'(bus.o_rd_valid),       32'h3);
    check_value("t4_data_rd0",   32'(bus.o_rd_data[15:0]),  32'h0BEE);
    check_value("t4_data_rd1",   32'(bus.o_rd_data[31:16]), 32'h0BEE);
    tick();
    drive_rd(0, 4'd2, 1'b0);
    drive_rd(1, 4'd2, 1'b0);
    #1;
    check_value("t4_occ_after",  32'(bus.o_occupancy), 32'd3);
    check_value("t4_valid_none", 32'(bus.o_rd_valid),  32'h0);

    // 5: fill all slots, then flush with a write pending
    model_full[3] = 1'b1;
    model_full[5] = 1'b1;
    model_full[7] = 1'b1;
    for (int i = 0; i < NE; i++) begin
      if (!model_full[i]) begin
        drive_wr(0, 1'b1, IW'(i), DW'(16'h0100 + i));
        tick();
        model_full[i] = 1'b1;
      end
    end
    drive_wr(0, 1'b1, 4'd0, 16'hDEAD);
    drive_wr(1, 1'b1, 4'd1, 16'hBEEF);
    #1;
    check_value("t5_full",       32'(bus.o_full),      32'd1);
    check_value("t5_occ16",      32'(bus.o_occupancy), 32'd16);
    check_value("t5_ready_full", 32'(bus.o_wr_ready),  32'h0);
    bus.i_flush = 1'b1;
    drive_wr(1, 1'b0, 4'd0, 16'h0000);
    #1;
    check_value("t5_ready_flush", 32'(bus.o_wr_ready), 32'h0);
    tick();
    bus.i_flush = 1'b0;
    drive_wr(0, 1'b0, 4'd0, 16'h0000);
    drive_rd(0, 4'd0, 1'b0);
    #1;
    check_value("t5_occ_flushed", 32'(bus.o_occupancy),   32'd0);
    check_value("t5_empty",       32'(bus.o_empty),       32'd1);
    check_value("t5_full_clear",  32'(bus.o_full),        32'd0);
    check_value("t5_valid_clear", 32'(bus.o_rd_valid[0]), 32'd0);
    bus.i_flush = 1'b1;
    drive_wr(0, 1'b1, 4'd9, 16'h5555);
    #1;
    check_value("t5_ready_flush_empty", 32'(bus.o_wr_ready[0]), 32'd0);
    tick();
    bus.i_flush = 1'b0;
    drive_wr(0, 1'b0, 4'd0, 16'h0000);
    drive_rd(0, 4'd9, 1'b0);
    #1;
    check_value("t5_flushed_write", 32'(bus.o_rd_valid[0]), 32'd0);
    check_value("t5_occ_zero",      32'(bus.o_occupancy),   32'd0);

    // 6: asynchronous reset with four slots full
    drive_wr(0, 1'b1, 4'd0, 16'h1000);
    drive_wr(1, 1'b1, 4'd1, 16'h1001);
    #1;
    check_value("t6_ready_dual", 32'(bus.o_wr_ready), 32'h3);
    tick();
    drive_wr(0, 1'b1, 4'd2, 16'h1002);
    drive_wr(1, 1'b1, 4'd3, 16'h1003);
    tick();
    drive_wr(0, 1'b0, 4'd0, 16'h0000);
    drive_wr(1, 1'b0, 4'd0, 16'h0000);
    drive_rd(0, 4'd0, 1'b0);
    drive_rd(1, 4'd1, 1'b0);
    #1;
    check_value("t6_occ4",     32'(bus.o_occupancy), 32'd4);
    check_value("t6_valid_pre", 32'(bus.o_rd_valid), 32'h3);
    #1;
    nrst = 1'b0;
    #1;
    check_value("t6_occ_rst",   32'(bus.o_occupancy), 32'd0);
    check_value("t6_valid_rst", 32'(bus.o_rd_valid),  32'h0);
    check_value("t6_empty_rst", 32'(bus.o_empty),     32'd1);
    #2;
    nrst = 1'b1;
    tick();
    drive_wr(0, 1'b1, 4'd0, 16'h0ABC);
    #1;
    check_value("t6_ready_post", 32'(bus.o_wr_ready[0]), 32'd1);
    tick();
    drive_wr(0, 1'b0, 4'd0, 16'h0000);
    #1;
    check_value("t6_valid_post", 32'(bus.o_rd_valid[0]),   32'd1);
    check_value("t6_data_post",  32'(bus.o_rd_data[15:0]), 32'h0ABC);
    check_value("t6_occ_post",   32'(bus.o_occupancy),     32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
